// File: rtl/rdma_meta_splitter.sv
// Splits RDMA tx_meta commands into chunks of at most 2^C_MAX_CHUNK_LOG2 bytes,
// advancing local/remote addresses per chunk and counting commands, chunks and dropped zero-length commands.
module rdma_meta_splitter #(
  parameter int C_META_WIDTH     = 256,
  parameter int C_MAX_CHUNK_LOG2 = 12
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      s_axis_meta_tvalid,
  output logic                      s_axis_meta_tready,
  input  logic [C_META_WIDTH-1:0]   s_axis_meta_tdata,
  input  logic [C_META_WIDTH/8-1:0] s_axis_meta_tkeep,
  input  logic                      s_axis_meta_tlast,
  output logic                      m_axis_meta_tvalid,
  input  logic                      m_axis_meta_tready,
  output logic [C_META_WIDTH-1:0]   m_axis_meta_tdata,
  output logic [C_META_WIDTH/8-1:0] m_axis_meta_tkeep,
  output logic                      m_axis_meta_tlast,
  output logic [31:0]               cmd_in_count,
  output logic [31:0]               chunk_out_count,
  output logic [31:0]               zero_len_count
);

  localparam logic [31:0] MAX_CHUNK = 32'(64'(1) << C_MAX_CHUNK_LOG2);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        rdy_q;
  logic [2:0]  op_q;
  logic [23:0] qpn_q;
  logic [47:0] laddr_q, raddr_q;
  logic [31:0] rem_q;
  logic [31:0] cmd_cnt_q, chunk_cnt_q, zero_cnt_q;

  logic [31:0] in_len;
  logic [31:0] chunk;
  logic        s_hs, m_hs;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis_meta_tkeep, s_axis_meta_tlast,
                           s_axis_meta_tdata[C_META_WIDTH-1:155]};

  assign in_len = s_axis_meta_tdata[154:123];
  assign chunk  = (rem_q > MAX_CHUNK) ? MAX_CHUNK : rem_q;
  assign s_hs   = s_axis_meta_tvalid & s_axis_meta_tready;
  assign m_hs   = m_axis_meta_tvalid & m_axis_meta_tready;

  // rdy_q keeps tready low until the first edge after reset release
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (s_hs && in_len != 32'd0) state_d = EMIT;
      EMIT: if (m_hs && rem_q == chunk)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_meta_tready = rdy_q && (state_q == IDLE);
    m_axis_meta_tvalid = (state_q == EMIT);
    m_axis_meta_tdata  = '0;
    m_axis_meta_tdata[2:0]     = op_q;
    m_axis_meta_tdata[26:3]    = qpn_q;
    m_axis_meta_tdata[74:27]   = laddr_q;
    m_axis_meta_tdata[122:75]  = raddr_q;
    m_axis_meta_tdata[154:123] = chunk;
    m_axis_meta_tkeep  = '1;
    m_axis_meta_tlast  = 1'b1;
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      op_q        <= '0;
      qpn_q       <= '0;
      laddr_q     <= '0;
      raddr_q     <= '0;
      rem_q       <= '0;
      cmd_cnt_q   <= '0;
      chunk_cnt_q <= '0;
      zero_cnt_q  <= '0;
    end else begin
      if (s_hs) begin
        op_q      <= s_axis_meta_tdata[2:0];
        qpn_q     <= s_axis_meta_tdata[26:3];
        laddr_q   <= s_axis_meta_tdata[74:27];
        raddr_q   <= s_axis_meta_tdata[122:75];
        rem_q     <= in_len;
        cmd_cnt_q <= cmd_cnt_q + 32'd1;
        if (in_len == 32'd0) zero_cnt_q <= zero_cnt_q + 32'd1;
      end
      if (m_hs) begin
        laddr_q     <= laddr_q + {16'd0, chunk};
        raddr_q     <= raddr_q + {16'd0, chunk};
        rem_q       <= rem_q - chunk;
        chunk_cnt_q <= chunk_cnt_q + 32'd1;
      end
    end
  end

  assign cmd_in_count    = cmd_cnt_q;
  assign chunk_out_count = chunk_cnt_q;
  assign zero_len_count  = zero_cnt_q;

endmodule

// File: tb/tb_rdma_meta_splitter.sv
// Directed and randomized bench for rdma_meta_splitter; expected chunk lists come
// from a queue-based model that slices each command arithmetically.
module tb_rdma_meta_splitter;

  logic         ap_clk = 1'b0;
  logic         areset;
  logic         s_tvalid, s_tready, s_tlast;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic         m_tvalid, m_tready, m_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [31:0]  cmd_in_count, chunk_out_count, zero_len_count;

  int total = 0;
  int bad   = 0;
  int n_cmd = 0, n_chunk = 0, n_zero = 0;

  always #5 ap_clk = ~ap_clk;

  rdma_meta_splitter dut (
    .ap_clk             (ap_clk),
    .areset             (areset),
    .s_axis_meta_tvalid (s_tvalid),
    .s_axis_meta_tready (s_tready),
    .s_axis_meta_tdata  (s_tdata),
    .s_axis_meta_tkeep  (s_tkeep),
    .s_axis_meta_tlast  (s_tlast),
    .m_axis_meta_tvalid (m_tvalid),
    .m_axis_meta_tready (m_tready),
    .m_axis_meta_tdata  (m_tdata),
    .m_axis_meta_tkeep  (m_tkeep),
    .m_axis_meta_tlast  (m_tlast),
    .cmd_in_count       (cmd_in_count),
    .chunk_out_count    (chunk_out_count),
    .zero_len_count     (zero_len_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack(input logic [2:0] op, input logic [23:0] qpn,
                                        input logic [47:0] la, input logic [47:0] ra,
                                        input logic [31:0] len);
    logic [255:0] v;
    v = '0;
    v[2:0]     = op;
    v[26:3]    = qpn;
    v[74:27]   = la;
    v[122:75]  = ra;
    v[154:123] = len;
    return v;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_cmd"},   256'(cmd_in_count),    256'(n_cmd));
    chk({tag, "_chunk"}, 256'(chunk_out_count), 256'(n_chunk));
    chk({tag, "_zero"},  256'(zero_len_count),  256'(n_zero));
  endtask

  // Present one command, then drain and compare every chunk against the model.
  task automatic run_cmd(input logic [2:0] op, input logic [23:0] qpn,
                         input logic [47:0] la, input logic [47:0] ra,
                         input logic [31:0] len, input bit rnd);
    logic [255:0] expq[$];
    logic [255:0] hold;
    logic [127:0] junk;
    logic [47:0]  a, b;
    logic [31:0]  rem, c;
    bit           held;
    int           cyc;
    rem = len; a = la; b = ra;
    while (rem != 0) begin
      c = (rem > 32'd4096) ? 32'd4096 : rem;
      expq.push_back(pack(op, qpn, a, b, c));
      a = a + 48'(c);
      b = b + 48'(c);
      rem = rem - c;
    end
    @(negedge ap_clk);
    junk = {$urandom, $urandom, $urandom, $urandom};
    s_tdata = pack(op, qpn, la, ra, len);
    s_tdata[255:155] = junk[100:0];
    s_tkeep = $urandom;
    s_tlast = 1'($urandom_range(0, 1));
    chk("s_ready_idle", 256'(s_tready), 256'(1));
    s_tvalid = 1'b1;
    @(negedge ap_clk);
    s_tvalid = 1'b0;
    n_cmd++;
    if (len == 32'd0) n_zero++;
    held = 1'b0;
    hold = '0;
    cyc  = 0;
    while (expq.size() > 0 && cyc < 5000) begin
      chk("m_valid_emit", 256'(m_tvalid), 256'(1));
      chk("s_ready_emit", 256'(s_tready), 256'(0));
      if (held) chk("stall_stable", m_tdata, hold);
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tready) begin
        chk("chunk", m_tdata, expq.pop_front());
        n_chunk++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hold = m_tdata;
      end
      @(negedge ap_clk);
      cyc++;
    end
    chk("emit_timeout", 256'(expq.size()), 256'(0));
    m_tready = 1'($urandom_range(0, 1));
    chk("m_valid_after", 256'(m_tvalid), 256'(0));
    chk("s_ready_after", 256'(s_tready), 256'(1));
    chk("tkeep", 256'(m_tkeep), 256'(32'hFFFF_FFFF));
    chk("tlast", 256'(m_tlast), 256'(1));
    chk_counters("cnt");
  endtask

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    #2;
    chk("rst_s_ready", 256'(s_tready), 256'(0));
    chk("rst_m_valid", 256'(m_tvalid), 256'(0));
    chk("rst_m_data", m_tdata, 256'(0));
    chk_counters("rst");
    @(negedge ap_clk);
    areset = 1'b0;
    chk("rel_s_ready_low", 256'(s_tready), 256'(0));
    @(negedge ap_clk);
    chk("rel_s_ready_high", 256'(s_tready), 256'(1));

    // basic split, exact one chunk, zero length, stalled emission, address wrap
    run_cmd(3'd1, 24'h00_0042, 48'h1000, 48'h0, 32'd10000, 1'b0);
    chk("ex1_chunks", 256'(chunk_out_count), 256'(3));
    chk("ex1_cmds", 256'(cmd_in_count), 256'(1));
    run_cmd(3'd2, 24'h12_3456, 48'hABC0, 48'h5000, 32'd4096, 1'b0);
    run_cmd(3'd3, 24'h00_0007, 48'h0, 48'h0, 32'd0, 1'b0);
    chk("zero_count", 256'(zero_len_count), 256'(1));
    run_cmd(3'd4, 24'hFF_FFFF, 48'h2_0000, 48'h9_0000, 32'd20000, 1'b1);
    run_cmd(3'd5, 24'h00_1111, 48'hFFFF_FFFF_F000, 48'h7, 32'd8192, 1'b0);
    run_cmd(3'd6, 24'h00_2222, 48'h10, 48'h20, 32'd1, 1'b1);
    run_cmd(3'd7, 24'h00_3333, 48'h10, 48'hFFFF_FFFF_FFFF, 32'd4097, 1'b1);

    // reset in the middle of a 3-chunk command
    @(negedge ap_clk);
    s_tdata  = pack(3'd1, 24'h55, 48'h4000, 48'h8000, 32'd12288);
    s_tvalid = 1'b1;
    @(negedge ap_clk);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    chk("rst_mid_first", m_tdata, pack(3'd1, 24'h55, 48'h4000, 48'h8000, 32'd4096));
    @(posedge ap_clk);
    #2;
    areset = 1'b1;
    #1;
    n_cmd = 0; n_chunk = 0; n_zero = 0;
    chk("rst_mid_m_valid", 256'(m_tvalid), 256'(0));
    chk("rst_mid_s_ready", 256'(s_tready), 256'(0));
    chk("rst_mid_m_data", m_tdata, 256'(0));
    chk_counters("rst_mid");
    @(negedge ap_clk);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      chk("post_rst_no_chunk", 256'(m_tvalid), 256'(0));
      chk("post_rst_s_ready", 256'(s_tready), 256'(1));
    end
    chk_counters("post_rst");
    run_cmd(3'd2, 24'h66, 48'h100, 48'h200, 32'd5000, 1'b0);

    for (int k = 0; k < 12; k++) begin
      logic [31:0] l;
      l = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 20000));
      run_cmd(3'($urandom), 24'($urandom), {16'($urandom), 32'($urandom)},
              {16'($urandom), 32'($urandom)}, l, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
